// File: rtl/usb_rx_deserializer_if.sv
// USB RX deserializer bus: synchronized line samples in, FIFO write port and packet status out.
interface usb_rx_deserializer_if;
  logic       bit_strobe;
  logic       d_plus;
  logic       d_minus;
  logic       fifo_full;
  logic       w_enable;
  logic [7:0] w_data;
  logic       rx_active;
  logic       packet_done;
  logic       rx_error;
  logic       rx_overflow;

  modport master (
    output bit_strobe, d_plus, d_minus, fifo_full,
    input  w_enable, w_data, rx_active, packet_done, rx_error, rx_overflow
  );
  modport slave (
    input  bit_strobe, d_plus, d_minus, fifo_full,
    output w_enable, w_data, rx_active, packet_done, rx_error, rx_overflow
  );
endinterface

// File: rtl/usb_rx_deserializer.sv
// USB FS receive bit-to-byte stage: NRZI decode, SYNC detect, bit unstuffing, EOP detect.
// Define RX_STUFF_CHECK_EN to treat a 1 in the stuff slot as a protocol error.
module usb_rx_deserializer #(
  parameter logic [7:0] SYNC_PATTERN = 8'h80,
  parameter int         STUFF_LIMIT  = 6
) (
  input logic                  clk,
  input logic                  rst,
  usb_rx_deserializer_if.slave bus
);
  localparam int OW = $clog2(STUFF_LIMIT + 1);

`ifdef RX_STUFF_CHECK_EN
  localparam bit STUFF_CHECK = 1'b1;
`else
  localparam bit STUFF_CHECK = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP1, EOP2, ERR_WAIT} state_t;

  state_t        state, state_n;
  logic          prev, prev_n;          // d_plus of the last strobed sample; J idles high
  logic [7:0]    shreg, shreg_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [OW-1:0] ones_cnt, ones_cnt_n;
  logic          se0_seen, se0_seen_n;
  logic          w_en_q, w_en_n;
  logic [7:0]    w_dat_q, w_dat_n;
  logic          active_q, active_n;
  logic          done_q, done_n;
  logic          err_q, err_n;
  logic          ovf_q, ovf_n;

  logic       line_se0, line_j, line_k, dbit;
  logic [7:0] shifted;

  assign line_se0 = (bus.d_plus == bus.d_minus);
  assign line_j   = bus.d_plus & ~bus.d_minus;
  assign line_k   = ~bus.d_plus & bus.d_minus;
  assign dbit     = (bus.d_plus == prev);
  assign shifted  = {dbit, shreg[7:1]};

  always_comb begin
    state_n    = state;
    prev_n     = prev;
    shreg_n    = shreg;
    bit_cnt_n  = bit_cnt;
    ones_cnt_n = ones_cnt;
    se0_seen_n = se0_seen;
    w_en_n     = 1'b0;
    w_dat_n    = w_dat_q;
    active_n   = active_q;
    done_n     = 1'b0;
    err_n      = err_q;
    ovf_n      = ovf_q;
    if (bus.bit_strobe) begin
      prev_n = bus.d_plus;
      case (state)
        IDLE: begin
          if (line_k) begin
            state_n    = SYNC;
            err_n      = 1'b0;
            ovf_n      = 1'b0;
            active_n   = 1'b1;
            shreg_n    = shifted;
            bit_cnt_n  = 3'd1;
            ones_cnt_n = '0;
          end
        end
        SYNC: begin
          shreg_n   = shifted;
          bit_cnt_n = bit_cnt + 3'd1;
          if (line_se0) begin
            err_n      = 1'b1;
            active_n   = 1'b0;
            se0_seen_n = 1'b1;
            state_n    = ERR_WAIT;
          end else if (bit_cnt == 3'd7) begin
            if (shifted == SYNC_PATTERN) begin
              state_n    = DATA;
              bit_cnt_n  = 3'd0;
              ones_cnt_n = OW'(1);
            end else begin
              err_n      = 1'b1;
              active_n   = 1'b0;
              se0_seen_n = 1'b0;
              state_n    = ERR_WAIT;
            end
          end
        end
        DATA: begin
          if (line_se0) begin
            state_n = EOP1;
            if (bit_cnt != 3'd0) begin
              err_n    = 1'b1;
              active_n = 1'b0;
            end
          end else if (ones_cnt == OW'(STUFF_LIMIT)) begin
            // Stuff slot: a 0 is dropped; a 1 is either dropped too or fatal.
            ones_cnt_n = '0;
            if (STUFF_CHECK && dbit) begin
              err_n      = 1'b1;
              active_n   = 1'b0;
              se0_seen_n = 1'b0;
              state_n    = ERR_WAIT;
            end
          end else begin
            shreg_n    = shifted;
            bit_cnt_n  = bit_cnt + 3'd1;
            ones_cnt_n = dbit ? ones_cnt + OW'(1) : '0;
            if (bit_cnt == 3'd7) begin
              if (bus.fifo_full) begin
                ovf_n = 1'b1;
              end else begin
                w_en_n  = 1'b1;
                w_dat_n = shifted;
              end
            end
          end
        end
        EOP1: begin
          if (line_se0) begin
            state_n = EOP2;
          end else begin
            err_n      = 1'b1;
            active_n   = 1'b0;
            se0_seen_n = 1'b0;
            state_n    = ERR_WAIT;
          end
        end
        EOP2: begin
          if (line_j) begin
            done_n   = ~err_q;
            active_n = 1'b0;
            state_n  = IDLE;
          end else begin
            err_n      = 1'b1;
            active_n   = 1'b0;
            se0_seen_n = line_se0;
            state_n    = ERR_WAIT;
          end
        end
        ERR_WAIT: begin
          active_n = 1'b0;
          if (line_se0) begin
            se0_seen_n = 1'b1;
          end else if (line_j && se0_seen) begin
            se0_seen_n = 1'b0;
            state_n    = IDLE;
          end else begin
            se0_seen_n = 1'b0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      prev     <= 1'b1;
      shreg    <= 8'h00;
      bit_cnt  <= 3'd0;
      ones_cnt <= '0;
      se0_seen <= 1'b0;
      w_en_q   <= 1'b0;
      w_dat_q  <= 8'h00;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state    <= state_n;
      prev     <= prev_n;
      shreg    <= shreg_n;
      bit_cnt  <= bit_cnt_n;
      ones_cnt <= ones_cnt_n;
      se0_seen <= se0_seen_n;
      w_en_q   <= w_en_n;
      w_dat_q  <= w_dat_n;
      active_q <= active_n;
      done_q   <= done_n;
      err_q    <= err_n;
      ovf_q    <= ovf_n;
    end
  end

  assign bus.w_enable    = w_en_q;
  assign bus.w_data      = w_dat_q;
  assign bus.rx_active   = active_q;
  assign bus.packet_done = done_q;
  assign bus.rx_error    = err_q;
  assign bus.rx_overflow = ovf_q;
endmodule

// File: doc/usb_rx_deserializer.md
# usb_rx_deserializer

Receive-side bit-to-byte stage of the USB full-speed data path. It sits directly upstream of the receive FIFO. It takes the synchronized D+/D- line samples on a bit strobe and performs NRZI decode, SYNC detection, bit unstuffing and EOP detection. It writes each assembled payload byte into the FIFO write port (w_enable/w_data) and reports per-packet status to the protocol controller.

## Interface
Parameters:
- SYNC_PATTERN, 8'h80, decoded SYNC byte. Bits are received LSB first.
- STUFF_LIMIT, 6, consecutive decoded 1s after which the next bit is a stuffed 0.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- bit_strobe  in  1  one-cycle pulse marking a valid line sample. Pulses may occur in consecutive cycles.
- d_plus  in  1  synchronized D+ sample.
- d_minus  in  1  synchronized D- sample.
- fifo_full  in  1  FIFO full flag.
- w_enable  out  1  FIFO write pulse, one cycle per byte.
- w_data  out  8  byte being written; valid when w_enable=1.
- rx_active  out  1  high from SYNC start until the packet ends or an error occurs.
- packet_done  out  1  one-cycle pulse on a clean EOP.
- rx_error  out  1  sticky flag for protocol error (bad SYNC, stuff error, partial byte, bad EOP).
- rx_overflow  out  1  sticky flag: a byte was dropped because the FIFO was full.

## Operation
- Line states:
  - J: d_plus=1, d_minus=0.
  - K: d_plus=0, d_minus=1.
  - SE0: both 0.
  - d_plus=1, d_minus=1 is treated as SE0.
- NRZI decode: the decoded bit is 1 when the line equals the previous sample, 0 on a transition. The previous-sample register resets to J and is updated only on bit_strobe.
- All state advances occur only on bit_strobe cycles.
- FSM states are IDLE, SYNC, DATA, EOP1, EOP2, ERR_WAIT.
- IDLE:
  - K sample → SYNC. Clear rx_error and rx_overflow, set rx_active, bit_cnt=1. The first decoded bit (0) is shifted in.
  - Otherwise stay in IDLE.
- SYNC:
  - Shift decoded bits right into the shift register (new bit to bit7).
  - After 8 bits, compare with SYNC_PATTERN.
  - Match → DATA, bit_cnt=0, ones_cnt=1 (the final SYNC bit is a 1).
  - Mismatch → set rx_error, then ERR_WAIT.
- DATA:
  - SE0 → EOP1. If bit_cnt≠0, set rx_error (partial byte discarded).
  - Else, if ones_cnt==STUFF_LIMIT and the decoded bit is 0: the bit is stuffed; discard it and set ones_cnt=0.
  - Else, if ones_cnt==STUFF_LIMIT and the decoded bit is 1: this is a stuff violation (see Configuration).
  - Else: shift the bit in and increment bit_cnt (3-bit, wraps 7→0). ones_cnt increments on 1, clears on 0.
  - When bit_cnt wraps to 0, the byte is complete:
    - If fifo_full=0: on the next cycle, pulse w_enable and present w_data = the byte.
    - If fifo_full=1: no write, set rx_overflow, reception continues.
- EOP1: SE0 → EOP2. Otherwise set rx_error and go to ERR_WAIT.
- EOP2:
  - J → pulse packet_done (only if rx_error=0), clear rx_active, go to IDLE.
  - Anything else → set rx_error, go to ERR_WAIT.
- ERR_WAIT:
  - rx_active is low in this state.
  - Wait for SE0 followed by J, then go to IDLE.
  - packet_done is never asserted on this path.
- rx_error and rx_overflow hold until the next IDLE→SYNC transition.

## Timing
- Reset values:
  - w_enable=0, w_data=8'h00, rx_active=0, packet_done=0, rx_error=0, rx_overflow=0.
  - FSM=IDLE, previous line=J, bit_cnt=0, ones_cnt=0.
- Latency: w_enable rises exactly one clk after the bit_strobe cycle that completes the byte. It lasts one cycle, with w_data stable in that cycle.
- packet_done rises one clk after the EOP2 J strobe.
- fifo_full is sampled in the same cycle as the completing strobe.
- A byte completing while w_enable is high (strobes in consecutive cycles) must still produce its own one-cycle write. At most one write per 8 strobes, so no queueing is needed.
- Reset asserted mid-packet: all state returns to reset values immediately. The partial byte is lost and no w_enable is issued after reset.

## Configuration
- RX_STUFF_CHECK_EN defined: a decoded 1 when ones_cnt==STUFF_LIMIT sets rx_error, clears rx_active and enters ERR_WAIT.
- RX_STUFF_CHECK_EN undefined: that bit is discarded as if stuffed, ones_cnt=0, reception continues, and no error is raised.

## Test plan
- Clean packet: SYNC, data bytes 0xA5 and 0x3C, then SE0,SE0,J → two writes with w_data=0xA5, then 0x3C; packet_done pulses once; rx_error=0.
- Bit stuffing: payload 0xFF,0xFF with stuffed zeros inserted → writes 0xFF,0xFF, and no stuffed bit appears in the data.
- Stuff violation: 7 consecutive decoded 1s in DATA. With RX_STUFF_CHECK_EN: rx_error=1, no packet_done. Without it: the bit is discarded and the following bytes are written.
- Overflow: fifo_full=1 during the second byte of a 3-byte packet → bytes 1 and 3 written, rx_overflow=1, packet_done pulses.
- Bad SYNC / partial byte: SYNC decoded as 0x81 → rx_error=1, no writes. Separately, EOP after 4 data bits → rx_error=1, no write, no packet_done.
- Reset mid-byte: assert rst after 5 data bits → all outputs return to 0 at once. The next clean packet is received correctly.
